dmem_responder: RTL and testbench

//  Data-memory responder for the CPU load/store port; the target end of the CPU's

---
 rtl/dmem_if.sv | 17 +
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the CPU load/store port and the data-memory responder
//  req_valid/req_ready  request handshake (initiator holds fields until accepted)
//  addr/wdata/mem_write request fields
//  rsp_valid            one-cycle response strobe
//  rdata/err            response fields, qualified by rsp_valid
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  modport master (output req_valid, addr, wdata, mem_write, input req_ready, rsp_valid, rdata, err);
  modport slave  (input req_valid, addr, wdata, mem_write, output req_ready, rsp_valid, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word responder serving a RAM, a cycle counter and a tohost register
//  clk     clock, rising edge
//  reset   asynchronous active-low reset
//  bus     dmem_if slave: request handshake in, response strobe/data/err out
//  tohost  current tohost register value
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter logic [31:0] CNT_INIT    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic [31:0] tohost
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [3:0]  WLOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [31:0]   addr_q, wdata_q, rdata_q, tohost_q, cnt_q;
  logic          we_q, err_q;
  logic [31:0]   mem [DEPTH];
  logic          accept, commit;
  logic [31:0]   a, wd, rdata_d;
  logic          w, aligned, is_ram, is_cnt, is_th, err_d;
  logic [AW-1:0] idx;
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign tohost        = tohost_q;
  assign accept        = bus.req_valid && bus.req_ready;
  // with no wait states the access commits on the accept edge, so decode the live request there
  assign a       = state_q == IDLE ? bus.addr      : addr_q;
  assign wd      = state_q == IDLE ? bus.wdata     : wdata_q;
  assign w       = state_q == IDLE ? bus.mem_write : we_q;
  assign idx     = a[AW+1:2];
  assign aligned = a[1:0] == 2'b00;
  assign is_ram  = a < 32'(DEPTH * 4);
  assign is_cnt  = a == MMIO_BASE;
  assign is_th   = a == MMIO_BASE + 32'd4;
  assign err_d   = !aligned || !(is_ram || is_cnt || is_th);
  assign rdata_d = (err_d || w) ? 32'd0 : is_ram ? mem[idx] : is_cnt ? cnt_q : tohost_q;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) state_d = RESP;
        else state_d = WAIT;
        wcnt_d = WLOAD;
        commit = WAIT_CYCLES == 0;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = RESP;
        wcnt_d = wcnt_q == 4'd0 ? 4'd0 : wcnt_q - 4'd1;
        commit = wcnt_q == 4'd0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      tohost_q <= 32'd0;
      cnt_q    <= CNT_INIT;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_q + 32'd1;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        we_q    <= bus.mem_write;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
        if (w && is_th && !err_d) tohost_q <= wd;
      end
    end
  end
  // RAM is not reset; reset gates the write so a request presented during reset never lands
  always_ff @(posedge clk) begin
    if (commit && reset && w && is_ram && !err_d) mem[idx] <= wd;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks dmem_responder against a transaction-level model of its memory map
module tb_dmem_responder;
  typedef struct {
    int          ce;
    logic [31:0] rd;
    logic        e;
    logic        wm;
    logic [5:0]  idx;
    logic [31:0] wd;
    logic        wt;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        d_v [2];
  logic        d_w [2];
  logic [31:0] d_a [2];
  logic [31:0] d_d [2];
  logic        rr  [2];
  logic        rsv [2];
  logic        er  [2];
  logic [31:0] rd  [2];
  logic [31:0] th  [2];
  exp_t        pend   [2];
  logic        pend_v [2];
  logic [31:0] mm     [2][64];
  logic [31:0] mth    [2];
  logic [31:0] mcnt   [2];
  int          nacc   [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  dmem_if b0 ();
  dmem_if b1 ();
  dmem_responder #(.WAIT_CYCLES(1)) u0 (.clk(clk), .reset(reset), .bus(b0), .tohost(th[0]));
  dmem_responder #(.WAIT_CYCLES(0), .CNT_INIT(32'hFFFF_FFF0)) u1 (.clk(clk), .reset(reset), .bus(b1), .tohost(th[1]));
  assign b0.req_valid = d_v[0];
  assign b0.addr      = d_a[0];
  assign b0.wdata     = d_d[0];
  assign b0.mem_write = d_w[0];
  assign b1.req_valid = d_v[1];
  assign b1.addr      = d_a[1];
  assign b1.wdata     = d_d[1];
  assign b1.mem_write = d_w[1];
  assign rr[0]  = b0.req_ready;
  assign rsv[0] = b0.rsp_valid;
  assign rd[0]  = b0.rdata;
  assign er[0]  = b0.err;
  assign rr[1]  = b1.req_ready;
  assign rsv[1] = b1.rsp_valid;
  assign rd[1]  = b1.rdata;
  assign er[1]  = b1.err;
  function automatic int wc(input int i);
    return i == 0 ? 1 : 0;
  endfunction
  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %h, expected %h", i, nm, act, exp);
    end
  endtask
  // outcome of a request from the memory map alone; writes are applied when the response appears
  function automatic exp_t predict(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t x;
    x.ce = cyc + wc(i);
    x.rd = 32'd0;
    x.e = 1'b0;
    x.wm = 1'b0;
    x.wt = 1'b0;
    x.idx = a[7:2];
    x.wd = d;
    if (a[1:0] != 2'b00 || !(a < 32'd256 || a == 32'h1000 || a == 32'h1004)) x.e = 1'b1;
    else if (a < 32'd256) begin
      if (w) x.wm = 1'b1;
      else x.rd = mm[i][a[7:2]];
    end
    else if (a == 32'h1000) x.rd = w ? 32'd0 : mcnt[i] + 32'(wc(i));
    else if (w) x.wt = 1'b1;
    else x.rd = mth[i];
    return x;
  endfunction
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        mcnt[i] = i == 0 ? 32'h0 : 32'hFFFF_FFF0;
        pend_v[i] = 1'b0;
      end else begin
        if (d_v[i] && rr[i]) begin
          if (pend_v[i]) chk(i, "accept_while_busy", 32'd1, 32'd0);
          pend[i] = predict(i, d_a[i], d_w[i], d_d[i]);
          pend_v[i] = 1'b1;
          nacc[i]++;
        end
        mcnt[i] = mcnt[i] + 32'd1;
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        pend_v[i] = 1'b0;
        mth[i] = 32'd0;
        chk(i, "rsp_valid_in_reset", 32'(rsv[i]), 32'd0);
      end else begin
        if (pend_v[i] && pend[i].ce == cyc) begin
          chk(i, "rsp_valid", 32'(rsv[i]), 32'd1);
          chk(i, "rdata", rd[i], pend[i].rd);
          chk(i, "err", 32'(er[i]), 32'(pend[i].e));
          if (pend[i].wm) mm[i][pend[i].idx] = pend[i].wd;
          if (pend[i].wt) mth[i] = pend[i].wd;
          pend_v[i] = 1'b0;
        end else chk(i, "rsp_valid_idle", 32'(rsv[i]), 32'd0);
        chk(i, "tohost", th[i], mth[i]);
      end
    end
  end
  task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [31:0] d, input int min_edge,
                      output logic [31:0] r, output logic e, output int t, output int rc);
    while (cyc < min_edge - 1) @(negedge clk);
    d_a[i] = a;
    d_w[i] = w;
    d_d[i] = d;
    d_v[i] = 1'b1;
    for (int k = 0; k < 50 && !rr[i]; k++) @(negedge clk);
    r = 32'd0;
    e = 1'b0;
    t = cyc + 1;
    rc = -1;
    if (!rr[i]) begin
      chk(i, "accept_timeout", 32'd0, 32'd1);
      d_v[i] = 1'b0;
      return;
    end
    @(negedge clk);
    d_v[i] = 1'b0;
    for (int k = 0; k < 20 && rc < 0; k++) begin
      if (rsv[i]) begin
        rc = cyc;
        r = rd[i];
        e = er[i];
      end else @(negedge clk);
    end
    if (rc < 0) chk(i, "rsp_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r, r1, v [12];
    logic        e;
    int          t, t1, rc, got;
    for (int i = 0; i < 2; i++) begin
      d_v[i] = 1'b0;
      d_w[i] = 1'b0;
      d_a[i] = 32'd0;
      d_d[i] = 32'd0;
      nacc[i] = 0;
      mth[i] = 32'd0;
      pend_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk(0, "reset_ready", 32'(rr[0]), 32'd1);
    chk(0, "reset_rsp_valid", 32'(rsv[0]), 32'd0);
    chk(0, "reset_rdata", rd[0], 32'd0);
    chk(0, "reset_err", 32'(er[0]), 32'd0);
    chk(1, "reset_tohost", th[1], 32'd0);
    reset = 1'b1;
    d_a[1] = 32'h1000;
    d_v[1] = 1'b1;
    got = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (rsv[1]) begin
        if (got < 12) v[got] = rd[1];
        got++;
      end
    end
    d_v[1] = 1'b0;
    chk(1, "cont_rsp_count", 32'(got), 32'd12);
    chk(1, "cont_acc_count", 32'(nacc[1]), 32'd12);
    chk(1, "cnt_first", v[0], 32'hFFFF_FFF0);
    chk(1, "cnt_pre_wrap", v[7], 32'hFFFF_FFFE);
    chk(1, "cnt_wrap", v[8], 32'h0000_0000);
    chk(1, "cnt_last", v[11], 32'h0000_0006);
    xfer(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 0, r, e, t, rc);
    chk(0, "st10_latency", 32'(rc - t), 32'd1);
    chk(0, "st10_err", 32'(e), 32'd0);
    chk(0, "st10_rdata", r, 32'd0);
    xfer(0, 32'h10, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld10_rdata", r, 32'hDEAD_BEEF);
    chk(0, "ld10_err", 32'(e), 32'd0);
    xfer(0, 32'h13, 1'b1, 32'h1234_5678, 0, r, e, t, rc);
    chk(0, "st13_err", 32'(e), 32'd1);
    chk(0, "st13_rdata", r, 32'd0);
    xfer(0, 32'h10, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld10_after_misaligned", r, 32'hDEAD_BEEF);
    xfer(0, 32'hFC, 1'b1, 32'hCAFE_F00D, 0, r, e, t, rc);
    xfer(0, 32'hFC, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ldFC_rdata", r, 32'hCAFE_F00D);
    xfer(0, 32'h100, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld100_err", 32'(e), 32'd1);
    xfer(0, 32'h800, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld800_err", 32'(e), 32'd1);
    chk(0, "ld800_rdata", r, 32'd0);
    xfer(0, 32'h1008, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld1008_err", 32'(e), 32'd1);
    xfer(0, 32'h1000, 1'b1, 32'h5555_0000, 0, r, e, t, rc);
    chk(0, "st1000_err", 32'(e), 32'd0);
    xfer(0, 32'h1004, 1'b1, 32'd1, 0, r, e, t, rc);
    chk(0, "st1004_err", 32'(e), 32'd0);
    chk(0, "tohost_in_resp", th[0], 32'd1);
    xfer(0, 32'h1004, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld1004_rdata", r, 32'd1);
    xfer(0, 32'h1000, 1'b0, 32'd0, 0, r1, e, t1, rc);
    xfer(0, 32'h1000, 1'b0, 32'd0, t1 + 5, r, e, t, rc);
    chk(0, "cnt_accept_gap", 32'(t - t1), 32'd5);
    chk(0, "cnt_delta", r - r1, 32'd5);
    xfer(0, 32'h20, 1'b1, 32'hAAAA_5555, 0, r, e, t, rc);
    d_a[0] = 32'h20;
    d_w[0] = 1'b1;
    d_d[0] = 32'h1111_2222;
    d_v[0] = 1'b1;
    for (int k = 0; k < 5 && !rr[0]; k++) @(negedge clk);
    @(negedge clk);
    d_v[0] = 1'b0;
    chk(0, "busy_in_wait", 32'(rr[0]), 32'd0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk(0, "ready_after_reset", 32'(rr[0]), 32'd1);
    chk(0, "tohost_after_reset", th[0], 32'd0);
    xfer(0, 32'h20, 1'b0, 32'd0, 0, r, e, t, rc);
    chk(0, "ld20_after_reset", r, 32'hAAAA_5555);
    repeat (3) @(negedge clk);
    chk(0, "no_pending", 32'(pend_v[0]), 32'd0);
    chk(1, "no_pending", 32'(pend_v[1]), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
